mem_stage_lsu: RTL

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_align.sv | 51 +++++
 rtl/mem_stage_lsu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and bus encodings for the memory-stage load/store unit.
// Used by mem_stage_lsu and its mem_align datapath.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'b00,
        MEM_HALF  = 2'b01,
        MEM_WORD  = 2'b10,
        MEM_DWORD = 2'b11
    } mem_size_t;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t LSU_IDLE = 2'b00;
    localparam lsu_state_t LSU_WAIT = 2'b01;
    localparam lsu_state_t LSU_DONE = 2'b10;

    typedef logic [1:0] bus_cmd_t;
    localparam bus_cmd_t BUS_NONE  = 2'b00;
    localparam bus_cmd_t BUS_LOAD  = 2'b01;
    localparam bus_cmd_t BUS_STORE = 2'b10;

    function automatic int size_bytes(input mem_size_t size);
        int n;
        case (size)
            MEM_BYTE:  n = 1;
            MEM_HALF:  n = 2;
            MEM_WORD:  n = 4;
            MEM_DWORD: n = 8;
            default:   n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  mem_size_t                 size,
    input  logic                      load_unsigned,
    input  logic [XLEN-1:0]           store_data,
    input  logic [XLEN-1:0]           load_data,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           store_lanes,
    output logic [XLEN-1:0]           load_result
);

    localparam int BW = XLEN / 8;

    int              nbytes_s;
    logic [BW-1:0]   mask_s;
    logic [XLEN-1:0] lane_s;

    // Byte-enable mask and store data replicated every size bytes
    always_comb begin
        nbytes_s    = size_bytes(size);
        mask_s      = '0;
        store_lanes = '0;
        for (int i = 0; i < BW; i++) begin
            mask_s[i] = (i < nbytes_s);
            store_lanes[8*i +: 8] = store_data[8*(i & (nbytes_s - 1)) +: 8];
        end
        be = mask_s << offset;
    end

    // Shift the addressed bytes down to bit 0, then extend to XLEN
    always_comb begin
        lane_s = load_data >> {offset, 3'b000};
        case (size)
            MEM_BYTE:  load_result = load_unsigned ? XLEN'(lane_s[7:0])
                                                   : XLEN'($signed(lane_s[7:0]));
            MEM_HALF:  load_result = load_unsigned ? XLEN'(lane_s[15:0])
                                                   : XLEN'($signed(lane_s[15:0]));
            MEM_WORD:  load_result = load_unsigned ? XLEN'(lane_s[31:0])
                                                   : XLEN'($signed(lane_s[31:0]));
            MEM_DWORD: load_result = lane_s;
            default:   load_result = lane_s;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one bus access per memory op,
// stalls the pipeline until ack or timeout, and returns the result.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     ex_mem_regb,
    input  logic [XLEN-1:0]     ex_mem_alu_result,
    input  logic                ex_mem_rd_mem,
    input  logic                ex_mem_wr_mem,
    input  logic [1:0]          ex_mem_mem_size,
    input  logic                ex_mem_mem_unsigned,
    input  logic                ex_mem_valid_inst,
    input  logic [XLEN-1:0]     Dmem2proc_data,
    input  logic                Dmem2proc_ack,
    output logic [XLEN-1:0]     mem_result_out,
    output logic                mem_stall,
    output logic                mem_misalign,
    output logic                mem_timeout,
    output logic [1:0]          proc2Dmem_command,
    output logic [XLEN-1:0]     proc2Dmem_addr,
    output logic [XLEN-1:0]     proc2Dmem_data,
    output logic [XLEN/8-1:0]   proc2Dmem_be
);

    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t      state_r;
    logic [CW-1:0]   wait_cnt_r;
    logic [XLEN-1:0] rdata_r;
    logic            timeout_r;

    mem_size_t       size_s;
    logic            mem_op_s;
    logic            is_load_s;
    logic            misalign_s;
    logic            start_s;
    logic            busy_s;
    logic            done_s;
    logic [BW-1:0]   be_s;
    logic [XLEN-1:0] lanes_s;
    logic [XLEN-1:0] load_res_s;

    assign size_s    = mem_size_t'(ex_mem_mem_size);
    assign mem_op_s  = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
    assign is_load_s = ex_mem_rd_mem & ~ex_mem_wr_mem;

    // Natural-alignment check; dword is illegal on a 32-bit datapath
    always_comb begin
        case (size_s)
            MEM_BYTE:  misalign_s = 1'b0;
            MEM_HALF:  misalign_s = ex_mem_alu_result[0];
            MEM_WORD:  misalign_s = |ex_mem_alu_result[1:0];
            MEM_DWORD: misalign_s = (XLEN == 32) | (|ex_mem_alu_result[2:0]);
            default:   misalign_s = 1'b1;
        endcase
    end

    // The timeout cycle must not relaunch the op still held on the inputs
    assign start_s = ~rst & ~timeout_r & (state_r == LSU_IDLE) & mem_op_s & ~misalign_s;
    assign busy_s  = start_s | (~rst & (state_r == LSU_WAIT));
    assign done_s  = ~rst & (state_r == LSU_DONE);

    mem_align #(.XLEN(XLEN)) u_align (
        .offset        (ex_mem_alu_result[OW-1:0]),
        .size          (size_s),
        .load_unsigned (ex_mem_mem_unsigned),
        .store_data    (ex_mem_regb),
        .load_data     (rdata_r),
        .be            (be_s),
        .store_lanes   (lanes_s),
        .load_result   (load_res_s)
    );

    // Access FSM, wait counter, read-data capture and timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LSU_IDLE;
            wait_cnt_r <= '0;
            rdata_r    <= '0;
            timeout_r  <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                LSU_IDLE: begin
                    if (start_s) begin
                        state_r    <= LSU_WAIT;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r <= LSU_IDLE;
                    end
                end
                LSU_WAIT: begin
                    if (Dmem2proc_ack) begin
                        state_r <= LSU_DONE;
                        rdata_r <= Dmem2proc_data;
                    end else if (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_r   <= LSU_IDLE;
                        timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                LSU_DONE: state_r <= LSU_IDLE;
                default:  state_r <= LSU_IDLE;
            endcase
        end
    end

    // Bus request and pipeline-facing outputs
    always_comb begin
        if (busy_s) begin
            proc2Dmem_command = ex_mem_wr_mem ? BUS_STORE : BUS_LOAD;
            proc2Dmem_be      = be_s;
        end else begin
            proc2Dmem_command = BUS_NONE;
            proc2Dmem_be      = '0;
        end
        if (done_s & is_load_s) begin
            mem_result_out = load_res_s;
        end else begin
            mem_result_out = ex_mem_alu_result;
        end
    end

    assign proc2Dmem_addr = {ex_mem_alu_result[XLEN-1:OW], {OW{1'b0}}};
    assign proc2Dmem_data = lanes_s;
    assign mem_stall      = busy_s;
    assign mem_misalign   = mem_op_s & misalign_s;
    assign mem_timeout    = timeout_r & ~rst;

endmodule
